// File: rtl/base_sram_pkg.sv
// Shared types and constants for the base SRAM sequencing controller.
package base_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_WR_REC = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int WAIT_CYC_DEF = 2;

endpackage

// File: rtl/base_sram_ctrl_arb.sv
// Fixed-priority requester grant; a port already pulsing ready is masked so a
// still-held request is not served twice.
module sram_req_arb
  import base_sram_pkg::*;
(
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic if_ready_i,
  input  logic mem_ready_i,
  output logic gnt_valid_o,
  output logic gnt_owner_o
);

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_owner_o = OWN_IF;
    // Data port first: the MEM-stage instruction is older than the fetch.
    if (mem_req_i && !mem_ready_i) begin
      gnt_valid_o = 1'b1;
      gnt_owner_o = OWN_MEM;
    end else if (if_req_i && !if_ready_i) begin
      gnt_valid_o = 1'b1;
      gnt_owner_o = OWN_IF;
    end
  end

endmodule

// File: rtl/base_sram_ctrl.sv
// Two-port sequencer for the shared 32-bit asynchronous base SRAM; every SRAM
// pin and ready output comes straight from a register.
//
// state     | meaning
// ST_IDLE   | strobes high, arbitrate between data and fetch ports
// ST_READ   | ce_n/oe_n low, count wait states, capture on count 0
// ST_WRITE  | ce_n/we_n low, bus driven, count wait states
// ST_WR_REC | we_n high, ce_n/address/data held for hold time
module base_sram_ctrl
  import base_sram_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  inout  wire  [31:0]       baseram_data,
  output logic [ADDR_W-1:0] baseram_addr,
  output logic [3:0]        baseram_be_n,
  output logic              baseram_ce_n,
  output logic              baseram_oe_n,
  output logic              baseram_we_n
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drv_q, drv_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic gnt_valid;
  logic gnt_owner;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  sram_req_arb u_arb (
    .if_req_i    (if_req),
    .mem_req_i   (mem_req),
    .if_ready_i  (if_ready_q),
    .mem_ready_i (mem_ready_q),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_n_d      = be_n_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    drv_d       = drv_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          cnt_d   = CNT_LOAD;
          ce_n_d  = 1'b0;
          addr_d  = (gnt_owner == OWN_MEM) ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          if (gnt_owner == OWN_MEM && mem_we) begin
            state_d = ST_WRITE;
            we_n_d  = 1'b0;
            drv_d   = 1'b1;
            wdata_d = mem_wdata;
            be_n_d  = ~mem_be;
          end else begin
            state_d = ST_READ;
            oe_n_d  = 1'b0;
            be_n_d  = 4'h0;
          end
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = baseram_data;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d  = baseram_data;
            if_ready_d  = 1'b1;
          end
          state_d = ST_IDLE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = 4'hF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_REC;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_REC: begin
        state_d     = ST_IDLE;
        ce_n_d      = 1'b1;
        drv_d       = 1'b0;
        be_n_d      = 4'hF;
        mem_ready_d = (owner_q == OWN_MEM);
        if_ready_d  = (owner_q == OWN_IF);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_n_q      <= 4'hF;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drv_q       <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_n_q      <= be_n_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drv_q       <= drv_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign baseram_data = drv_q ? wdata_q : 32'hzzzz_zzzz;
  assign baseram_addr = addr_q;
  assign baseram_be_n = be_n_q;
  assign baseram_ce_n = ce_n_q;
  assign baseram_oe_n = oe_n_q;
  assign baseram_we_n = we_n_q;
  assign if_ready     = if_ready_q;
  assign mem_ready    = mem_ready_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;

endmodule

// File: tb/tb_base_sram_ctrl.sv
// Scoreboard bench for base_sram_ctrl: main instance at WAIT_CYC=2 with an SRAM
// model, plus WAIT_CYC=1 and 4 instances for latency.
module tb_base_sram_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_ready, mem_ready;
  wire  [31:0] baseram_data;
  logic [19:0] baseram_addr;
  logic [3:0]  baseram_be_n;
  logic        baseram_ce_n, baseram_oe_n, baseram_we_n;

  logic [31:0] sram [0:255];

  base_sram_ctrl #(.WAIT_CYC(2), .ADDR_W(20)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .baseram_data(baseram_data), .baseram_addr(baseram_addr), .baseram_be_n(baseram_be_n),
    .baseram_ce_n(baseram_ce_n), .baseram_oe_n(baseram_oe_n), .baseram_we_n(baseram_we_n)
  );

  assign baseram_data = (!baseram_ce_n && !baseram_oe_n && baseram_we_n) ?
                        sram[baseram_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!baseram_ce_n && !baseram_we_n)
      for (int i = 0; i < 4; i++)
        if (!baseram_be_n[i]) sram[baseram_addr[7:0]][8*i +: 8] <= baseram_data[8*i +: 8];
  end

  // Latency-sweep instances share the data-port fields but have private requests.
  logic        w1_req, w4_req, sw_we;
  logic [31:0] sw_addr, sw_wdata;
  logic [3:0]  sw_be;
  logic [31:0] w1_rdata, w4_rdata;
  logic        w1_ready, w4_ready;
  wire  [31:0] w1_data, w4_data;
  logic        w1_ce_n, w1_oe_n, w4_ce_n, w4_oe_n;
  logic [31:0] unused_w1_if_rdata, unused_w4_if_rdata;
  logic        unused_w1_if_ready, unused_w4_if_ready, unused_w1_we_n, unused_w4_we_n;
  logic [19:0] unused_w1_addr, unused_w4_addr;
  logic [3:0]  unused_w1_be_n, unused_w4_be_n;

  base_sram_ctrl #(.WAIT_CYC(1), .ADDR_W(20)) u_w1 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(unused_w1_if_rdata), .if_ready(unused_w1_if_ready),
    .mem_req(w1_req), .mem_we(sw_we), .mem_be(sw_be), .mem_addr(sw_addr),
    .mem_wdata(sw_wdata), .mem_rdata(w1_rdata), .mem_ready(w1_ready),
    .baseram_data(w1_data), .baseram_addr(unused_w1_addr), .baseram_be_n(unused_w1_be_n),
    .baseram_ce_n(w1_ce_n), .baseram_oe_n(w1_oe_n), .baseram_we_n(unused_w1_we_n)
  );

  base_sram_ctrl #(.WAIT_CYC(4), .ADDR_W(20)) u_w4 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(unused_w4_if_rdata), .if_ready(unused_w4_if_ready),
    .mem_req(w4_req), .mem_we(sw_we), .mem_be(sw_be), .mem_addr(sw_addr),
    .mem_wdata(sw_wdata), .mem_rdata(w4_rdata), .mem_ready(w4_ready),
    .baseram_data(w4_data), .baseram_addr(unused_w4_addr), .baseram_be_n(unused_w4_be_n),
    .baseram_ce_n(w4_ce_n), .baseram_oe_n(w4_oe_n), .baseram_we_n(unused_w4_we_n)
  );

  assign w1_data = (!w1_ce_n && !w1_oe_n) ? 32'h0000_0101 : 32'hzzzz_zzzz;
  assign w4_data = (!w4_ce_n && !w4_oe_n) ? 32'h0404_0404 : 32'hzzzz_zzzz;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t q_if[$], q_mem[$], q_w1[$], q_w4[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (if_ready) begin
      chk("if_ready_expected", q_if.size() > 0, 1);
      if (q_if.size() > 0) begin
        e = q_if.pop_front();
        chk("if_ready_cycle", cyc, e.cyc);
        if (e.chk_data) chk("if_rdata", if_rdata, e.data);
      end
    end
    if (mem_ready) begin
      chk("mem_ready_expected", q_mem.size() > 0, 1);
      if (q_mem.size() > 0) begin
        e = q_mem.pop_front();
        chk("mem_ready_cycle", cyc, e.cyc);
        if (e.chk_data) chk("mem_rdata", mem_rdata, e.data);
      end
    end
    if (w1_ready) begin
      chk("w1_ready_expected", q_w1.size() > 0, 1);
      if (q_w1.size() > 0) begin
        e = q_w1.pop_front();
        chk("w1_ready_cycle", cyc, e.cyc);
        if (e.chk_data) chk("w1_rdata", w1_rdata, e.data);
      end
    end
    if (w4_ready) begin
      chk("w4_ready_expected", q_w4.size() > 0, 1);
      if (q_w4.size() > 0) begin
        e = q_w4.pop_front();
        chk("w4_ready_cycle", cyc, e.cyc);
        if (e.chk_data) chk("w4_rdata", w4_rdata, e.data);
      end
    end
  end

  // Requesters hold through their ready cycle and drop the cycle after.
  task automatic serve(input int budget);
    logic d_if = 1'b0, d_mem = 1'b0, d_w1 = 1'b0, d_w4 = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (d_if)  if_req  = 1'b0;
      if (d_mem) mem_req = 1'b0;
      if (d_w1)  w1_req  = 1'b0;
      if (d_w4)  w4_req  = 1'b0;
      if (if_ready)  d_if  = 1'b1;
      if (mem_ready) d_mem = 1'b1;
      if (w1_ready)  d_w1  = 1'b1;
      if (w4_ready)  d_w4  = 1'b1;
      if (!if_req && !mem_req && !w1_req && !w4_req) break;
    end
    chk("serve_done", {if_req, mem_req, w1_req, w4_req}, 0);
    if_req = 1'b0; mem_req = 1'b0; w1_req = 1'b0; w4_req = 1'b0;
  endtask

  task automatic push(input int port, input logic [31:0] d, input logic cd, input int lat);
    exp_t e;
    e.data = d; e.chk_data = cd; e.cyc = cyc + lat;
    case (port)
      0: q_if.push_back(e);
      1: q_mem.push_back(e);
      2: q_w1.push_back(e);
      default: q_w4.push_back(e);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[4]    = 32'hDEAD_BEEF;
    sram[5]    = 32'h0BAD_F00D;
    sram[8'h40] = 32'hAABB_CCDD;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'h0; mem_addr = '0; mem_wdata = '0;
    w1_req = 1'b0; w4_req = 1'b0; sw_we = 1'b0; sw_addr = '0; sw_wdata = '0; sw_be = 4'h0;

    repeat (2) @(negedge clk);
    chk("rst_ce_n", baseram_ce_n, 1);
    chk("rst_oe_n", baseram_oe_n, 1);
    chk("rst_we_n", baseram_we_n, 1);
    chk("rst_be_n", baseram_be_n, 4'hF);
    chk("rst_addr", baseram_addr, 0);
    chk("rst_ready", {if_ready, mem_ready}, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // IF read of word 4
    push(0, 32'hDEAD_BEEF, 1'b1, 3);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("rd_addr", baseram_addr, 20'h4);
    chk("rd_c1_ce_oe_we", {baseram_ce_n, baseram_oe_n, baseram_we_n}, 3'b001);
    chk("rd_c1_be_n", baseram_be_n, 4'h0);
    @(negedge clk);
    chk("rd_c2_oe_n", baseram_oe_n, 0);
    serve(20);
    chk("rd_no_reissue_c4", baseram_ce_n, 1);
    @(negedge clk);
    chk("rd_no_reissue_c5", baseram_ce_n, 1);

    // Partial-byte write to 0x100 then read-back
    push(1, 32'h0, 1'b0, 4);
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h0000_0100;
    mem_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_c1_ce_oe_we", {baseram_ce_n, baseram_oe_n, baseram_we_n}, 3'b010);
    chk("wr_be_n", baseram_be_n, 4'b1100);
    chk("wr_addr", baseram_addr, 20'h40);
    chk("wr_c1_bus", baseram_data, 32'h1234_5678);
    @(negedge clk);
    chk("wr_c2_we_n", baseram_we_n, 0);
    @(negedge clk);
    chk("wr_rec_ce_we", {baseram_ce_n, baseram_we_n}, 2'b01);
    chk("wr_rec_bus", baseram_data, 32'h1234_5678);
    serve(20);
    mem_we = 1'b0;
    push(1, 32'hAABB_5678, 1'b1, 3);
    mem_req = 1'b1;
    serve(20);

    // Simultaneous requests: data first, fetch granted in the mem_ready cycle
    push(1, 32'hAABB_5678, 1'b1, 3);
    push(0, 32'h0BAD_F00D, 1'b1, 6);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100;
    if_req = 1'b1; if_addr = 32'h0000_0014;
    serve(30);

    // Reset in cycle 1 of a write
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h0000_0200;
    mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstw_c1_we_n", baseram_we_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("rstw_async_strobes", {baseram_ce_n, baseram_oe_n, baseram_we_n}, 3'b111);
    chk("rstw_async_be_n", baseram_be_n, 4'hF);
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rstw_no_write", sram[8'h80], 32'h0);
    @(negedge clk);
    push(1, 32'hAABB_5678, 1'b1, 3);
    mem_req = 1'b1; mem_addr = 32'h0000_0100;
    serve(20);

    // WAIT_CYC sweep: read 2/5, write 3/6 cycles
    push(2, 32'h0000_0101, 1'b1, 2);
    push(3, 32'h0404_0404, 1'b1, 5);
    sw_we = 1'b0; sw_addr = 32'h0000_0020;
    w1_req = 1'b1; w4_req = 1'b1;
    serve(30);
    push(2, 32'h0, 1'b0, 3);
    push(3, 32'h0, 1'b0, 6);
    sw_we = 1'b1; sw_be = 4'hF; sw_wdata = 32'h5555_AAAA;
    w1_req = 1'b1; w4_req = 1'b1;
    serve(30);
    sw_we = 1'b0;

    repeat (4) @(negedge clk);
    chk("q_if_empty", q_if.size(), 0);
    chk("q_mem_empty", q_mem.size(), 0);
    chk("q_w1_empty", q_w1.size(), 0);
    chk("q_w4_empty", q_w4.size(), 0);
    chk("end_idle_ce_n", baseram_ce_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
